// File: rtl/sumador_serie_ctrl.sv
// -----------------------------------------------------------------------------
// sumador_serie_ctrl
//   Bit-serial N-bit adder. A single 1-bit full adder (sumador_completo_1_bit)
//   is reused over N clock cycles, LSB first. The carry between bit positions
//   is held in a register. A start/busy/done handshake sequences each
//   operation: IDLE -> RUN (N cycles) -> DONE (1 cycle) -> IDLE.
//
// Ports
//   clk    in   1  system clock, rising edge
//   rst_n  in   1  asynchronous reset, active-low
//   start  in   1  request, sampled only while idle
//   a, b   in   N  operands, captured on the accepting edge
//   c_in   in   1  carry input, captured on the accepting edge
//   busy   out  1  high from the accepting edge until the end of DONE
//   done   out  1  one-cycle pulse, result valid
//   s      out  N  sum, held until the next result
//   c_out  out  1  carry out of bit N-1, held
//   ovf    out  1  signed overflow (carry into MSB xor carry out), held
// -----------------------------------------------------------------------------
module sumador_serie_ctrl #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c_in,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] s,
    output logic         c_out,
    output logic         ovf
);

    localparam int CNT_W = (N > 2) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e           state_q;
    logic [N-1:0]     a_sh_q;
    logic [N-1:0]     b_sh_q;
    logic [N-1:0]     res_sh_q;
    logic [N-1:0]     res_sh_d;
    logic             carry_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [N-1:0]     s_q;
    logic             c_out_q;
    logic             ovf_q;
    logic             fa_s_s;
    logic             fa_c_s;

    sumador_completo_1_bit u_fa (
        .x_i (a_sh_q[0]),
        .y_i (b_sh_q[0]),
        .c_i (carry_q),
        .s_o (fa_s_s),
        .c_o (fa_c_s)
    );

    // New sum bit enters at the MSB end; after N shifts bit 0 sits at position 0.
    assign res_sh_d = (res_sh_q >> 1) | {fa_s_s, {(N-1){1'b0}}};

    // Sequencer: operand capture, per-bit shifting and result publication.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            s_q      <= '0;
            c_out_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_sh_q  <= a;
                        b_sh_q  <= b;
                        carry_q <= c_in;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    res_sh_q <= res_sh_d;
                    carry_q  <= fa_c_s;
                    a_sh_q   <= a_sh_q >> 1;
                    b_sh_q   <= b_sh_q >> 1;
                    cnt_q    <= cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST) begin
                        // On the MSB step carry_q is the carry into the MSB,
                        // so overflow is that carry xor the final carry out.
                        s_q     <= res_sh_d;
                        c_out_q <= fa_c_s;
                        ovf_q   <= carry_q ^ fa_c_s;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign s     = s_q;
    assign c_out = c_out_q;
    assign ovf   = ovf_q;

endmodule

// -----------------------------------------------------------------------------
// sumador_completo_1_bit
//   Combinational 1-bit full adder.
//   x_i, y_i  in  operand bits
//   c_i       in  carry in
//   s_o       out sum bit
//   c_o       out carry out
// -----------------------------------------------------------------------------
module sumador_completo_1_bit (
    input  logic x_i,
    input  logic y_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);

    assign s_o = x_i ^ y_i ^ c_i;
    assign c_o = (x_i & y_i) | (c_i & (x_i ^ y_i));

endmodule

// File: tb/tb_sumador_serie_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sumador_serie_ctrl
//   Self-checking bench for the bit-serial adder: an N=8 instance for the
//   directed, random, streaming and reset cases and an N=2 instance for the
//   exhaustive sweep. Expected results come from plain integer arithmetic.
// -----------------------------------------------------------------------------
module tb_sumador_serie_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;

    logic       start8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       c8;
    logic       busy8;
    logic       done8;
    logic [7:0] s8;
    logic       co8;
    logic       ovf8;

    logic       start2;
    logic [1:0] a2;
    logic [1:0] b2;
    logic       c2;
    logic       busy2;
    logic       done2;
    logic [1:0] s2;
    logic       co2;
    logic       ovf2;

    int n_tests = 0;
    int n_fail  = 0;

    sumador_serie_ctrl #(.N(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .c_in  (c8),
        .busy  (busy8),
        .done  (done8),
        .s     (s8),
        .c_out (co8),
        .ovf   (ovf8)
    );

    sumador_serie_ctrl #(.N(2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start2),
        .a     (a2),
        .b     (b2),
        .c_in  (c2),
        .busy  (busy2),
        .done  (done2),
        .s     (s2),
        .c_out (co2),
        .ovf   (ovf2)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: bit 31 = signed overflow, low bits = unsigned a+b+c (w+1 bits).
    function automatic logic [31:0] ref_add(input int w, input int av, input int bv, input int cv);
        int  u;
        int  sa;
        int  sb;
        int  ss;
        logic ov;
        u  = av + bv + cv;
        sa = (av >= (1 << (w - 1))) ? av - (1 << w) : av;
        sb = (bv >= (1 << (w - 1))) ? bv - (1 << w) : bv;
        ss = sa + sb + cv;
        ov = (ss > ((1 << (w - 1)) - 1)) || (ss < -(1 << (w - 1)));
        return {ov, 31'(u)};
    endfunction

    // One N=8 operation with latency, busy-length, hold and result checks.
    task automatic op8(input logic [7:0] ta, input logic [7:0] tbv, input logic tc);
        logic [31:0] r;
        logic [7:0]  s_prev;
        int          lat;
        int          busy_n;
        r      = ref_add(8, int'(ta), int'(tbv), int'(tc));
        s_prev = s8;
        @(negedge clk);
        a8 = ta; b8 = tbv; c8 = tc; start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
        lat    = -1;
        busy_n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy8) busy_n++;
            if (done8) begin
                lat = i;
                break;
            end
            chk("s_held_during_run", 32'(s8), 32'(s_prev));
            a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
        end
        chk("latency8", 32'(lat), 32'd8);
        chk("busy_cycles8", 32'(busy_n), 32'd9);
        chk("sum8", 32'(s8), 32'(r[7:0]));
        chk("c_out8", 32'(co8), 32'(r[8]));
        chk("ovf8", 32'(ovf8), 32'(r[31]));
        @(negedge clk);
        chk("done_pulse8", 32'(done8), 32'd0);
        chk("busy_idle8", 32'(busy8), 32'd0);
        chk("sum8_hold", 32'(s8), 32'(r[7:0]));
    endtask

    // One N=2 operation.
    task automatic op2(input logic [1:0] ta, input logic [1:0] tbv, input logic tc);
        logic [31:0] r;
        int          lat;
        r = ref_add(2, int'(ta), int'(tbv), int'(tc));
        @(negedge clk);
        a2 = ta; b2 = tbv; c2 = tc; start2 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        a2 = ~ta; b2 = ~tbv; c2 = ~tc;
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done2) begin
                lat = i;
                break;
            end
        end
        chk("latency2", 32'(lat), 32'd2);
        chk("sum2", 32'({co2, s2}), 32'(r[2:0]));
        chk("ovf2", 32'(ovf2), 32'(r[31]));
        @(negedge clk);
        chk("done_pulse2", 32'(done2), 32'd0);
    endtask

    // Start held high with operands changing every cycle.
    task automatic stream8();
        logic [7:0]  qa [0:39];
        logic [7:0]  qb [0:39];
        logic        qc [0:39];
        logic [31:0] r;
        logic [7:0]  exp_s;
        logic        exp_c;
        logic        exp_o;
        exp_s = s8; exp_c = co8; exp_o = ovf8;
        for (int m = 0; m < 40; m++) begin
            @(negedge clk);
            if (m >= 9 && ((m - 9) % 10) == 0) begin
                r = ref_add(8, int'(qa[m-9]), int'(qb[m-9]), int'(qc[m-9]));
                exp_s = r[7:0]; exp_c = r[8]; exp_o = r[31];
                chk("stream_done", 32'(done8), 32'd1);
            end else begin
                chk("stream_nodone", 32'(done8), 32'd0);
            end
            chk("stream_s", 32'(s8), 32'(exp_s));
            chk("stream_c_out", 32'(co8), 32'(exp_c));
            chk("stream_ovf", 32'(ovf8), 32'(exp_o));
            qa[m] = 8'($urandom); qb[m] = 8'($urandom); qc[m] = 1'($urandom);
            a8 = qa[m]; b8 = qb[m]; c8 = qc[m]; start8 = 1'b1;
        end
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        chk("stream_idle", 32'(busy8), 32'd0);
    endtask

    // Reset asserted while the bit counter is at 4.
    task automatic reset_mid_op();
        int dones;
        @(negedge clk);
        a8 = 8'hA5; b8 = 8'h3C; c8 = 1'b1; start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        for (int i = 0; i <= 4; i++) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_busy", 32'(busy8), 32'd0);
        chk("rst_done", 32'(done8), 32'd0);
        chk("rst_s", 32'(s8), 32'd0);
        chk("rst_c_out", 32'(co8), 32'd0);
        chk("rst_ovf", 32'(ovf8), 32'd0);
        #1;
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done8) dones++;
        end
        chk("rst_no_done", 32'(dones), 32'd0);
        chk("rst_idle", 32'(busy8), 32'd0);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // Main stimulus sequence.
    initial begin
        rst_n  = 1'b0;
        start8 = 1'b0; a8 = 8'h00; b8 = 8'h00; c8 = 1'b0;
        start2 = 1'b0; a2 = 2'b00; b2 = 2'b00; c2 = 1'b0;
        #2;
        chk("reset_busy", 32'(busy8), 32'd0);
        chk("reset_done", 32'(done8), 32'd0);
        chk("reset_s", 32'(s8), 32'd0);
        chk("reset_c_out", 32'(co8), 32'd0);
        chk("reset_ovf", 32'(ovf8), 32'd0);
        #10;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_busy", 32'(busy8), 32'd0);
        chk("post_reset_s", 32'(s8), 32'd0);

        op8(8'h0F, 8'h01, 1'b0);
        op8(8'hFF, 8'h01, 1'b0);
        op8(8'h7F, 8'h01, 1'b0);
        op8(8'hFF, 8'hFF, 1'b1);
        op8(8'h80, 8'h80, 1'b0);
        op8(8'h00, 8'h00, 1'b1);
        for (int k = 0; k < 20; k++) begin
            op8(8'($urandom), 8'($urandom), 1'($urandom));
        end

        stream8();

        reset_mid_op();
        op8(8'h12, 8'h34, 1'b0);

        for (int v = 0; v < 32; v++) begin
            logic [4:0] vv;
            vv = 5'(v);
            op2(vv[4:3], vv[2:1], vv[0]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
